// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port RAM between the instruction fetch
// and data memory requesters. One access is in flight at a time. The owner is
// answered with a one-cycle ihit/dhit pulse and a registered load word. A
// watchdog bounds the variable RAM latency and raises a sticky err flag.
module memory_arbiter #(
  parameter int          TIMEOUT_CYC = 64,
  parameter logic [31:0] ERR_WORD    = 32'hBAD1_BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        err
);

  localparam int             CW       = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0]  LAST_CNT = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic          grant_d;
  logic [CW-1:0] busy_cnt;
  logic          timed_out;
  logic [31:0]   resp_word;

  // Word handed back at the end of BUSY: RAM data for reads, zero for writes,
  // the error word when the watchdog gives up on the RAM.
  always_comb begin
    timed_out = 1'b0;
    resp_word = ERR_WORD;
    if (ram_ready) begin
      resp_word = ramWEN ? 32'h0 : ramload;
    end else if (busy_cnt == LAST_CNT) begin
      timed_out = 1'b1;
    end
  end

  // Arbitration FSM; every output is a register so nothing feeds through
  // combinationally from the request inputs to the hits or the RAM port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      grant_d  <= 1'b0;
      busy_cnt <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= 32'h0;
      dload    <= 32'h0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= 32'h0;
      ramstore <= 32'h0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ihit     <= 1'b0;
          dhit     <= 1'b0;
          busy_cnt <= '0;
          if (dREN || dWEN) begin
            grant_d  <= 1'b1;
            ramWEN   <= dWEN;
            ramREN   <= ~dWEN;
            ramaddr  <= daddr;
            ramstore <= dstore;
            state    <= BUSY;
          end else if (iREN) begin
            grant_d  <= 1'b0;
            ramWEN   <= 1'b0;
            ramREN   <= 1'b1;
            ramaddr  <= iaddr;
            ramstore <= 32'h0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          busy_cnt <= busy_cnt + 1'b1;
          if (ram_ready || timed_out) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (timed_out) begin
              err <= 1'b1;
            end
            if (grant_d) begin
              dhit  <= 1'b1;
              dload <= resp_word;
            end else begin
              ihit  <= 1'b1;
              iload <= resp_word;
            end
            state <= RESP;
          end
        end
        RESP: begin
          ihit     <= 1'b0;
          dhit     <= 1'b0;
          busy_cnt <= '0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: drives directed and randomized instruction/data accesses
// into memory_arbiter, answers them from a latency-programmable RAM model,
// and predicts every hit, load word, latency and err value from the access
// rules using a separate reference memory image.
module tb_memory_arbiter;

  localparam int          T    = 4;
  localparam logic [31:0] ERRW = 32'hBAD1_BAD1;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic [31:0] iload, dload;
  logic        ihit, dhit;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic        ram_ready;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;
  int iHits = 0, dHits = 0;
  int iExp  = 0, dExp  = 0;
  bit errModel = 1'b0;

  logic [31:0] ramMem [0:63];
  logic [31:0] refMem [0:63];
  int ramLatency = 1;
  int ramCycle   = 0;

  always #5 CLK = ~CLK;

  memory_arbiter #(.TIMEOUT_CYC(T), .ERR_WORD(ERRW)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .err(err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // RAM model: answers after ramLatency enabled cycles (0 = never answers),
  // shows garbage on ramload while not ready.
  always @(posedge CLK) begin
    #1;
    if (ramREN || ramWEN) ramCycle++;
    else ramCycle = 0;
    if ((ramREN || ramWEN) && ramLatency != 0 && ramCycle == ramLatency) begin
      ram_ready = 1'b1;
      if (ramWEN) ramMem[ramaddr[7:2]] = ramstore;
      ramload = ramMem[ramaddr[7:2]];
    end else begin
      ram_ready = 1'b0;
      ramload   = $urandom;
    end
  end

  // Hit monitor: counts pulses and flags any cycle with both hits high.
  always @(negedge CLK) begin
    if (!RST && (ihit || dhit)) begin
      checkOutput("oneHitPerCycle", {31'b0, ihit & dhit}, 32'h0);
      if (ihit) iHits++;
      if (dhit) dHits++;
    end
  end

  // Waits from the current negedge for the owner's hit, checking the RAM port
  // on every cycle before it and the response on the hit cycle.
  task automatic waitHit(input string tag, input bit isData, input bit isWrite,
                         input logic [31:0] addr, input logic [31:0] store,
                         input logic [31:0] expLoad, input int expCycles, input bit expErr);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (ihit || dhit) begin
        seen = 1'b1;
      end else begin
        checkOutput({tag, ".ramaddr"}, ramaddr, addr);
        checkOutput({tag, ".ramREN"}, {31'b0, ramREN}, {31'b0, !isWrite});
        checkOutput({tag, ".ramWEN"}, {31'b0, ramWEN}, {31'b0, isWrite});
        if (isWrite) checkOutput({tag, ".ramstore"}, ramstore, store);
      end
    end
    if (!seen) begin
      checkOutput({tag, ".hitArrived"}, 32'h0, 32'h1);
    end else begin
      checkOutput({tag, ".latency"}, 32'(cyc), 32'(expCycles));
      checkOutput({tag, ".owner"}, {30'b0, dhit, ihit}, isData ? 32'h2 : 32'h1);
      checkOutput({tag, ".load"}, isData ? dload : iload, expLoad);
      checkOutput({tag, ".err"}, {31'b0, err}, {31'b0, expErr});
      checkOutput({tag, ".respEnables"}, {30'b0, ramREN, ramWEN}, 32'h0);
    end
  endtask

  // One access from the requester's point of view: raise the request at an
  // IDLE-cycle negedge, hold it through the hit edge, return at the next negedge.
  task automatic applyStimulus(input string tag, input bit isData, input bit isWrite,
                               input logic [31:0] addr, input logic [31:0] store, input int lat);
    bit          timedOut = (lat == 0) || (lat > T);
    int          busyCycles = timedOut ? T : lat;
    logic [31:0] expLoad;
    expLoad = timedOut ? ERRW : (isWrite ? 32'h0 : refMem[addr[7:2]]);
    if (isWrite && !timedOut) refMem[addr[7:2]] = store;
    if (timedOut) errModel = 1'b1;
    ramLatency = lat;
    iREN   = !isData;
    dWEN   = isData && isWrite;
    dREN   = isData && (!isWrite || ($urandom_range(0, 1) == 1));
    iaddr  = isData ? $urandom : addr;
    daddr  = isData ? addr : $urandom;
    dstore = store;
    if (isData) dExp++;
    else iExp++;
    waitHit(tag, isData, isWrite, addr, store, expLoad, 2 + busyCycles - 1, errModel);
    @(negedge CLK);
  endtask

  task automatic releaseRequests();
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      ramMem[i] = $urandom;
      refMem[i] = ramMem[i];
    end
    ramMem[16] = 32'h2402000A;
    refMem[16] = 32'h2402000A;
    ram_ready = 1'b0;
    ramload   = 32'h0;
    RST = 1'b1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;

    // Reset state
    @(negedge CLK);
    checkOutput("rst.hits", {30'b0, ihit, dhit}, 32'h0);
    checkOutput("rst.enables", {30'b0, ramREN, ramWEN}, 32'h0);
    checkOutput("rst.err", {31'b0, err}, 32'h0);
    checkOutput("rst.iload", iload, 32'h0);
    checkOutput("rst.dload", dload, 32'h0);
    checkOutput("rst.ramaddr", ramaddr, 32'h0);
    checkOutput("rst.ramstore", ramstore, 32'h0);
    RST = 1'b0;
    @(negedge CLK);

    // Single instruction read answered in the first BUSY cycle
    applyStimulus("singleRead", 1'b0, 1'b0, 32'h40, 32'h0, 1);
    releaseRequests();
    @(negedge CLK);

    // Simultaneous requests: data wins, instruction follows
    ramLatency = 3;
    iREN = 1'b1; iaddr = 32'h24;
    dREN = 1'b1; dWEN = 1'b0; daddr = 32'h38; dstore = $urandom;
    dExp++; iExp++;
    waitHit("dualData", 1'b1, 1'b0, 32'h38, 32'h0, refMem[14], 4, errModel);
    @(negedge CLK);
    dREN = 1'b0;
    waitHit("dualInstr", 1'b0, 1'b0, 32'h24, 32'h0, refMem[9], 4, errModel);
    @(negedge CLK);
    releaseRequests();
    @(negedge CLK);

    // No preemption: a write raised during an instruction access waits
    ramLatency = 3;
    iREN = 1'b1; iaddr = 32'h20;
    iExp++;
    @(negedge CLK);
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEADBEEF;
    dExp++;
    waitHit("npInstr", 1'b0, 1'b0, 32'h20, 32'h0, refMem[8], 3, errModel);
    @(negedge CLK);
    iREN = 1'b0;
    refMem[32] = 32'hDEADBEEF;
    waitHit("npWrite", 1'b1, 1'b1, 32'h80, 32'hDEADBEEF, 32'h0, 4, errModel);
    @(negedge CLK);
    releaseRequests();
    @(negedge CLK);
    applyStimulus("npReadBack", 1'b1, 1'b0, 32'h80, 32'h0, 2);

    // Back-to-back instruction reads with the address advancing on each hit
    for (int k = 0; k < 6; k++) begin
      applyStimulus("b2bRead", 1'b0, 1'b0, 32'(4 * k), 32'h0, 1 + (k % 3));
    end
    releaseRequests();
    repeat (3) @(negedge CLK);

    // Watchdog timeout followed by a good access with err still set
    applyStimulus("timeout", 1'b1, 1'b0, 32'h10, 32'h0, 0);
    applyStimulus("afterTimeout", 1'b0, 1'b0, 32'h14, 32'h0, 2);
    releaseRequests();
    @(negedge CLK);

    // Reset in the middle of a BUSY access
    ramLatency = 0;
    iREN = 1'b1; iaddr = 32'h30;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("midRst.enables", {30'b0, ramREN, ramWEN}, 32'h0);
    checkOutput("midRst.hits", {30'b0, ihit, dhit}, 32'h0);
    checkOutput("midRst.err", {31'b0, err}, 32'h0);
    RST = 1'b0;
    errModel = 1'b0;
    releaseRequests();
    @(negedge CLK);

    // Randomized mix; timeouts only on reads
    for (int n = 0; n < 40; n++) begin
      bit          isData  = ($urandom_range(0, 1) == 1);
      bit          isWrite = isData && ($urandom_range(0, 1) == 1);
      logic [31:0] addr    = 32'($urandom_range(0, 15)) << 2;
      int          lat     = isWrite ? int'($urandom_range(1, T)) : int'($urandom_range(0, T + 1));
      applyStimulus("rand", isData, isWrite, addr, $urandom, lat);
      if ($urandom_range(0, 2) == 0) begin
        releaseRequests();
        repeat ($urandom_range(0, 2)) @(negedge CLK);
      end
    end
    releaseRequests();
    repeat (4) @(negedge CLK);

    checkOutput("iHitCount", 32'(iHits), 32'(iExp));
    checkOutput("dHitCount", 32'(dHits), 32'(dExp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
